// File: rtl/oclib_ready_valid_downsizer.sv
// oclib_ready_valid_downsizer
// Width-down converter for ready/valid streams: each InWidth-bit word is split into
// Ratio = InWidth/OutWidth beats of OutWidth bits, and the final beat is flagged with
// outLast. The last-beat accept and the next word load can happen in the same cycle,
// so a steady stream runs at one beat per cycle with no bubbles.
// Compile-time option OCLIB_RV_DOWNSIZER_MSB_FIRST_EN: emit the most significant
// slice first (default: least significant slice first).
module oclib_ready_valid_downsizer #(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [InWidth-1:0]  inData,
  input  logic                inValid,
  output logic                inReady,
  output logic [OutWidth-1:0] outData,
  output logic                outValid,
  output logic                outLast,
  input  logic                outReady
);

  localparam int Ratio = (OutWidth > 0) ? (InWidth / OutWidth) : 1;
  localparam int BeatW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  // Reject widths that cannot be split into whole beats.
  generate
    if (OutWidth <= 0) begin : g_bad_out_width
      $error("oclib_ready_valid_downsizer: OutWidth must be non-zero");
    end else if ((InWidth % OutWidth) != 0) begin : g_bad_ratio
      $error("oclib_ready_valid_downsizer: InWidth must be a multiple of OutWidth");
    end
  endgenerate

  logic                r_live;
  logic                r_full;
  logic [BeatW-1:0]    r_beat;
  logic [InWidth-1:0]  r_hold;

  logic                w_last;
  logic                w_out_acc;
  logic                w_in_acc;
  logic                w_in_ready;
  logic [OutWidth-1:0] w_out_data;

  assign w_last     = r_full && (r_beat == LastBeat);
  assign w_out_acc  = r_full && outReady;
  // A new word may load when empty, or when the final beat leaves this same cycle.
  assign w_in_ready = r_live && (!r_full || (w_out_acc && w_last));
  assign w_in_acc   = inValid && w_in_ready;

  assign inReady  = w_in_ready;
  assign outValid = r_full;
  assign outLast  = w_last;
  assign outData  = w_out_data;

  // Input side stays closed during reset and opens on the first edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Holding register, occupancy flag and beat index; hold only loads on an accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_beat <= '0;
      r_hold <= '0;
    end else if (w_in_acc) begin
      r_hold <= inData;
      r_full <= 1'b1;
      r_beat <= '0;
    end else if (w_out_acc) begin
      if (w_last) begin
        r_full <= 1'b0;
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Beat selector: route the slice addressed by the beat index to the output.
  always_comb begin
    w_out_data = '0;
    for (int i = 0; i < Ratio; i++) begin
      if (r_beat == BeatW'(i)) begin
`ifdef OCLIB_RV_DOWNSIZER_MSB_FIRST_EN
        w_out_data = r_hold[(Ratio-1-i)*OutWidth +: OutWidth];
`else
        w_out_data = r_hold[i*OutWidth +: OutWidth];
`endif
      end
    end
  end

endmodule

// File: tb/tb_oclib_ready_valid_downsizer.sv
// Bench for oclib_ready_valid_downsizer: a 32->8 instance and an 8->8 instance,
// checked against a queue-based reference model of the beat stream.
module tb_oclib_ready_valid_downsizer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic [31:0] inData_a = '0;
  logic        inValid_a = 1'b0;
  logic        inReady_a;
  logic [7:0]  outData_a;
  logic        outValid_a;
  logic        outLast_a;
  logic        outReady_a = 1'b0;

  logic [7:0]  inData_b = '0;
  logic        inValid_b = 1'b0;
  logic        inReady_b;
  logic [7:0]  outData_b;
  logic        outValid_b;
  logic        outLast_b;
  logic        outReady_b = 1'b0;

  always #5 clock = ~clock;

  oclib_ready_valid_downsizer #(.InWidth(32), .OutWidth(8)) dut_a (
    .clock(clock), .reset(reset),
    .inData(inData_a), .inValid(inValid_a), .inReady(inReady_a),
    .outData(outData_a), .outValid(outValid_a), .outLast(outLast_a), .outReady(outReady_a)
  );

  oclib_ready_valid_downsizer #(.InWidth(8), .OutWidth(8)) dut_b (
    .clock(clock), .reset(reset),
    .inData(inData_b), .inValid(inValid_b), .inReady(inReady_b),
    .outData(outData_b), .outValid(outValid_b), .outLast(outLast_b), .outReady(outReady_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] obs_a[$];
  int         obs_cyc[$];
  bit         live = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_b_out = 0;
  int         t_acc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [7:0] slice_of(input logic [31:0] w, input int i);
    int k;
`ifdef OCLIB_RV_DOWNSIZER_MSB_FIRST_EN
    k = 3 - i;
`else
    k = i;
`endif
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction

  function automatic bit exp_ready_a();
    return live && ((q_a.size() == 0) || ((q_a.size() == 1) && outReady_a));
  endfunction

  function automatic bit exp_ready_b();
    return live && ((q_b.size() == 0) || outReady_b);
  endfunction

  // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic step(output bit acc_a, output bit acc_b);
    bit         pop_a, pop_b;
    logic [7:0] d_now;
    beat_t      b;
    @(negedge clock);
    acc_a = 1'b0; acc_b = 1'b0; pop_a = 1'b0; pop_b = 1'b0;
    d_now = outData_a;
    if (!reset) begin
      check("rst_in_ready_a", inReady_a, 0);
      check("rst_out_valid_a", outValid_a, 0);
      check("rst_out_last_a", outLast_a, 0);
      check("rst_out_data_a", outData_a, 0);
      check("rst_in_ready_b", inReady_b, 0);
      check("rst_out_valid_b", outValid_b, 0);
    end else begin
      check("in_ready_a", inReady_a, exp_ready_a());
      check("out_valid_a", outValid_a, q_a.size() != 0);
      if (q_a.size() != 0) begin
        check("out_data_a", outData_a, q_a[0].d);
        check("out_last_a", outLast_a, q_a[0].l);
      end
      check("in_ready_b", inReady_b, exp_ready_b());
      check("out_valid_b", outValid_b, q_b.size() != 0);
      check("out_last_b", outLast_b, q_b.size() != 0);
      if (q_b.size() != 0) check("out_data_b", outData_b, q_b[0]);
      acc_a = inValid_a && exp_ready_a();
      acc_b = inValid_b && exp_ready_b();
      pop_a = (q_a.size() != 0) && outReady_a;
      pop_b = (q_b.size() != 0) && outReady_b;
      if (acc_a) t_acc = cyc;
    end
    @(posedge clock);
    if (!reset) begin
      live = 1'b0;
      q_a.delete();
      q_b.delete();
    end else begin
      if (pop_a) begin
        obs_a.push_back(d_now);
        obs_cyc.push_back(cyc);
        void'(q_a.pop_front());
      end
      if (acc_a) begin
        for (int i = 0; i < 4; i++) begin
          b.d = slice_of(inData_a, i);
          b.l = (i == 3);
          q_a.push_back(b);
        end
      end
      if (pop_b) begin
        void'(q_b.pop_front());
        n_b_out++;
      end
      if (acc_b) q_b.push_back(inData_b);
      live = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic send_a(input logic [31:0] w, output int waited);
    bit acc, y;
    acc = 1'b0;
    waited = 0;
    inValid_a = 1'b1;
    inData_a = w;
    for (int c = 0; c < 20 && !acc; c++) begin
      step(acc, y);
      waited++;
    end
    inValid_a = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  task automatic drain_a();
    bit x, y;
    for (int c = 0; c < 40 && q_a.size() != 0; c++) step(x, y);
    check("drain_done", q_a.size(), 0);
  endtask

  task automatic check_obs(input string tag, input logic [7:0] e[8], input int n);
    check({tag, "_count"}, obs_a.size(), n);
    for (int i = 0; i < n && i < obs_a.size(); i++) check(tag, obs_a[i], e[i]);
  endtask

  initial begin
    bit         x, y, acc_a, acc_b, got;
    int         w;
    logic [7:0] e[8];
    bit         pat[4];

    // Reset held low 3 cycles with a word offered.
    inValid_a = 1'b1;
    inData_a = 32'h12345678;
    repeat (3) step(x, y);
    reset = 1'b1;
    step(x, y);
    check("t1_ready_before_edge", x, 0);
    inValid_a = 1'b0;
    step(x, y);
    check("t1_no_beat", obs_a.size(), 0);

    // Basic split.
    outReady_a = 1'b1;
    obs_a.delete(); obs_cyc.delete();
    send_a(32'hA1B2C3D4, w);
    drain_a();
`ifdef OCLIB_RV_DOWNSIZER_MSB_FIRST_EN
    e = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    e = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    check_obs("t2_beat", e, 4);
    if (obs_cyc.size() == 4) begin
      check("t2_latency", obs_cyc[0], t_acc + 1);
      check("t2_span", obs_cyc[3] - obs_cyc[0], 3);
    end

    // Back-to-back words with no bubble.
    obs_a.delete(); obs_cyc.delete();
    send_a(32'h03020100, w);
    send_a(32'h07060504, w);
    check("t3_wait", w, 4);
    drain_a();
`ifdef OCLIB_RV_DOWNSIZER_MSB_FIRST_EN
    e = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h07, 8'h06, 8'h05, 8'h04};
`else
    e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
`endif
    check_obs("t3_beat", e, 8);
    if (obs_cyc.size() == 8) check("t3_span", obs_cyc[7] - obs_cyc[0], 7);

    // Backpressure pattern 1,0,0,1.
    obs_a.delete(); obs_cyc.delete();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    got = 1'b0;
    inValid_a = 1'b1;
    inData_a = 32'h11223344;
    for (int c = 0; c < 40 && !(got && q_a.size() == 0); c++) begin
      outReady_a = pat[c % 4];
      step(acc_a, y);
      if (acc_a) begin
        got = 1'b1;
        inValid_a = 1'b0;
      end
    end
    inValid_a = 1'b0;
    outReady_a = 1'b1;
    check("t4_done", got && (q_a.size() == 0), 1);
`ifdef OCLIB_RV_DOWNSIZER_MSB_FIRST_EN
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    e = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    check_obs("t4_beat", e, 4);

    // Reset in the middle of a word.
    send_a(32'h55667788, w);
    step(x, y);
    step(x, y);
    reset = 1'b0;
    #1;
    check("t5_valid_async", outValid_a, 0);
    check("t5_ready_async", inReady_a, 0);
    step(x, y);
    reset = 1'b1;
    step(x, y);
    check("t5_empty", q_a.size(), 0);
    obs_a.delete(); obs_cyc.delete();
    send_a(32'hDEADBEEF, w);
    drain_a();
`ifdef OCLIB_RV_DOWNSIZER_MSB_FIRST_EN
    e = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    e = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    check_obs("t5_beat", e, 4);

    // Random traffic on both instances; 1000 words through the 8->8 slice.
    acc_a = 1'b0; acc_b = 1'b0;
    n_b_out = 0;
    for (int c = 0; c < 8000 && n_b_out < 1000; c++) begin
      if (acc_a || !inValid_a) begin
        inValid_a = ($urandom_range(0, 3) != 0);
        inData_a = $urandom;
      end
      if (acc_b || !inValid_b) begin
        inValid_b = ($urandom_range(0, 3) != 0);
        inData_b = 8'($urandom);
      end
      outReady_a = ($urandom_range(0, 3) != 0);
      outReady_b = ($urandom_range(0, 3) != 0);
      step(acc_a, acc_b);
    end
    check("t6_words", n_b_out >= 1000, 1);
    inValid_a = 1'b0;
    inValid_b = 1'b0;
    outReady_a = 1'b1;
    outReady_b = 1'b1;
    drain_a();
    step(x, y);
    check("t6_b_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
